// File: rtl/relu_maxpool2x2.sv
// ReLU followed by 2x2 stride-2 max-pooling over a raster-ordered fp32 pixel stream.
// One pooled pixel is emitted per 2x2 window, one clock after the window's last input pixel.
module relu_maxpool2x2 #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 32,
  parameter int HEIGHT     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  frame_done
);

  localparam int CW  = (WIDTH  > 2) ? $clog2(WIDTH)     : 1;
  localparam int RW  = (HEIGHT > 2) ? $clog2(HEIGHT)    : 1;
  localparam int LBW = (WIDTH  > 2) ? $clog2(WIDTH / 2) : 1;

  typedef enum logic {ROW_EVEN, ROW_ODD} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [DATA_WIDTH-1:0] r_hpair;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_valid_out;
  logic                  r_frame_done;
  logic [DATA_WIDTH-1:0] r_linebuf [WIDTH/2];

  logic [DATA_WIDTH-1:0] w_relu;
  logic [DATA_WIDTH-1:0] w_pair_max;
  logic [DATA_WIDTH-1:0] w_lb_rd;
  logic [DATA_WIDTH-1:0] w_result;
  logic [LBW-1:0]        w_lb_idx;
  logic                  w_last_col;
  logic                  w_last_row;

  // After ReLU every word is non-negative, so an unsigned compare orders them as fp32.
  assign w_relu     = data_in[DATA_WIDTH-1] ? '0 : data_in;
  assign w_pair_max = (r_hpair > w_relu) ? r_hpair : w_relu;
  assign w_lb_idx   = LBW'(r_col >> 1);
  assign w_lb_rd    = r_linebuf[w_lb_idx];
  assign w_result   = (w_lb_rd > w_pair_max) ? w_lb_rd : w_pair_max;
  assign w_last_col = (r_col == CW'(WIDTH - 1));
  assign w_last_row = (r_row == RW'(HEIGHT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ROW_EVEN;
      r_col        <= '0;
      r_row        <= '0;
      r_hpair      <= '0;
      r_data_out   <= '0;
      r_valid_out  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_valid_out  <= 1'b0;
      r_frame_done <= 1'b0;
      if (valid_in) begin
        if (w_last_col) begin
          r_col   <= '0;
          r_row   <= w_last_row ? '0 : r_row + RW'(1);
          r_state <= (r_state == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
        end else begin
          r_col <= r_col + CW'(1);
        end

        if (!r_col[0]) begin
          r_hpair <= w_relu;
        end else if (r_state == ROW_ODD) begin
          r_data_out   <= w_result;
          r_valid_out  <= 1'b1;
          r_frame_done <= w_last_col && w_last_row;
        end
      end
    end
  end

  // Line buffer is deliberately not reset; each entry is written in an even row before it is read.
  always_ff @(posedge clk) begin
    if (rst && valid_in && r_col[0] && (r_state == ROW_EVEN))
      r_linebuf[w_lb_idx] <= w_pair_max;
  end

  assign data_out   = r_data_out;
  assign valid_out  = r_valid_out;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// Bench for relu_maxpool2x2: 2x2, 4x4 and 32x32 instances share data_in and reset,
// each with its own valid_in; directed vector table plus gapped, back-to-back and reset sequences.
module tb_relu_maxpool2x2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic        v2, v4, v32;
  logic [31:0] d2o, d4o, d32o;
  logic        v2o, v4o, v32o;
  logic        f2o, f4o, f32o;

  always #5 clk = ~clk;

  relu_maxpool2x2 #(.DATA_WIDTH(32), .WIDTH(2), .HEIGHT(2)) u2 (
    .clk(clk), .rst(rst), .data_in(din), .valid_in(v2),
    .data_out(d2o), .valid_out(v2o), .frame_done(f2o));

  relu_maxpool2x2 #(.DATA_WIDTH(32), .WIDTH(4), .HEIGHT(4)) u4 (
    .clk(clk), .rst(rst), .data_in(din), .valid_in(v4),
    .data_out(d4o), .valid_out(v4o), .frame_done(f4o));

  relu_maxpool2x2 #(.DATA_WIDTH(32), .WIDTH(32), .HEIGHT(32)) u32 (
    .clk(clk), .rst(rst), .data_in(din), .valid_in(v32),
    .data_out(d32o), .valid_out(v32o), .frame_done(f32o));

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] q2d [$];
  logic        q2f [$];
  logic [31:0] q4d [$];
  logic        q4f [$];
  logic [31:0] q32d [$];
  logic        q32f [$];

  logic [31:0] fr [0:2047];

  always @(negedge clk) begin
    if (v2o)  begin q2d.push_back(d2o);   q2f.push_back(f2o);   end
    if (v4o)  begin q4d.push_back(d4o);   q4f.push_back(f4o);   end
    if (v32o) begin q32d.push_back(d32o); q32f.push_back(f32o); end
  end

  typedef struct packed {
    logic [1:0]        sel;
    logic [15:0][31:0] px;
    logic [2:0]        n_out;
    logic [3:0][31:0]  exp_d;
    logic [3:0]        exp_f;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic push(input int sel, input logic [31:0] v);
    @(negedge clk);
    din = v;
    v2  = (sel == 0);
    v4  = (sel == 1);
    v32 = (sel == 2);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      v2 = 1'b0; v4 = 1'b0; v32 = 1'b0;
    end
  endtask

  function automatic logic [31:0] relu(input logic [31:0] v);
    return v[31] ? 32'h0 : v;
  endfunction

  function automatic logic [31:0] mx(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [31:0] pool(input int w, input int base, input int wr, input int wc);
    int p;
    p = base + 2 * wr * w + 2 * wc;
    return mx(mx(relu(fr[p]), relu(fr[p + 1])), mx(relu(fr[p + w]), relu(fr[p + w + 1])));
  endfunction

  initial begin
    logic [31:0] t [16];
    logic [31:0] qd [$];
    logic        qf [$];
    logic [31:0] cd;
    logic        cv, cf;
    int          np, nf;

    t = '{default: 32'h0};
    vecs[0] = '0; vecs[1] = '0; vecs[2] = '0; vecs[3] = '0;

    t[0:3] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    vecs[0].sel = 2'd0; vecs[0].n_out = 3'd1;
    for (int k = 0; k < 4; k++) vecs[0].px[k] = t[k];
    vecs[0].exp_d[0] = 32'h40800000; vecs[0].exp_f = 4'b0001;

    t[0:3] = '{32'hBF800000, 32'hC0000000, 32'h80000000, 32'hBF000000};
    vecs[1].sel = 2'd0; vecs[1].n_out = 3'd1;
    for (int k = 0; k < 4; k++) vecs[1].px[k] = t[k];
    vecs[1].exp_d[0] = 32'h00000000; vecs[1].exp_f = 4'b0001;

    t = '{default: 32'h3F800000};
    t[7] = 32'h40A00000;
    vecs[2].sel = 2'd1; vecs[2].n_out = 3'd4;
    for (int k = 0; k < 16; k++) vecs[2].px[k] = t[k];
    vecs[2].exp_d[0] = 32'h3F800000; vecs[2].exp_d[1] = 32'h40A00000;
    vecs[2].exp_d[2] = 32'h3F800000; vecs[2].exp_d[3] = 32'h3F800000;
    vecs[2].exp_f = 4'b1000;

    t = '{32'hC0000000, 32'h3F000000, 32'h40400000, 32'h40000000,
          32'h3E800000, 32'h80000000, 32'h40400000, 32'h40E00000,
          32'h41000000, 32'h00000000, 32'hBF800000, 32'hBF800000,
          32'h3F800000, 32'h40000000, 32'hC1000000, 32'h80000000};
    vecs[3].sel = 2'd1; vecs[3].n_out = 3'd4;
    for (int k = 0; k < 16; k++) vecs[3].px[k] = t[k];
    vecs[3].exp_d[0] = 32'h3F000000; vecs[3].exp_d[1] = 32'h40E00000;
    vecs[3].exp_d[2] = 32'h41000000; vecs[3].exp_d[3] = 32'h00000000;
    vecs[3].exp_f = 4'b1000;

    // reset state
    rst = 1'b0; din = 32'h0; v2 = 1'b0; v4 = 1'b0; v32 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_d2", d2o, 32'h0);   check("rst_v2", 32'(v2o), 32'h0);  check("rst_f2", 32'(f2o), 32'h0);
    check("rst_d4", d4o, 32'h0);   check("rst_v4", 32'(v4o), 32'h0);
    check("rst_d32", d32o, 32'h0); check("rst_v32", 32'(v32o), 32'h0);
    rst = 1'b1;
    idle(2);

    // directed table
    for (int i = 0; i < 4; i++) begin
      np = (vecs[i].sel == 2'd0) ? 4 : 16;
      q2d.delete(); q2f.delete(); q4d.delete(); q4f.delete();
      for (int k = 0; k < np; k++) push(int'(vecs[i].sel), vecs[i].px[k]);
      idle(1);
      if (vecs[i].sel == 2'd0) begin cv = v2o; cf = f2o; end
      else begin cv = v4o; cf = f4o; end
      check($sformatf("v%0d_latency_valid", i), 32'(cv), 32'h1);
      check($sformatf("v%0d_latency_fd", i), 32'(cf), 32'h1);
      idle(2);
      if (vecs[i].sel == 2'd0) begin cd = d2o; cv = v2o; qd = q2d; qf = q2f; end
      else begin cd = d4o; cv = v4o; qd = q4d; qf = q4f; end
      check($sformatf("v%0d_hold_data", i), cd, vecs[i].exp_d[int'(vecs[i].n_out) - 1]);
      check($sformatf("v%0d_valid_low", i), 32'(cv), 32'h0);
      check($sformatf("v%0d_count", i), 32'(qd.size()), 32'(vecs[i].n_out));
      for (int j = 0; j < int'(vecs[i].n_out) && j < qd.size(); j++) begin
        check($sformatf("v%0d_out%0d", i, j), qd[j], vecs[i].exp_d[j]);
        check($sformatf("v%0d_fd%0d", i, j), 32'(qf[j]), 32'(vecs[i].exp_f[j]));
      end
    end

    // gapped 4x4
    q4d.delete(); q4f.delete();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        fr[r * 4 + c] = $urandom;
        push(1, fr[r * 4 + c]);
        idle($urandom_range(0, 5));
      end
      idle(2);
      check($sformatf("gap_row%0d_count", r), 32'(q4d.size()), 32'(((r + 1) / 2) * 2));
    end
    for (int j = 0; j < 4 && j < q4d.size(); j++) begin
      check($sformatf("gap_out%0d", j), q4d[j], pool(4, 0, j / 2, j % 2));
      check($sformatf("gap_fd%0d", j), 32'(q4f[j]), 32'(j == 3));
    end

    // back-to-back 32x32 frames
    q32d.delete(); q32f.delete();
    for (int k = 0; k < 2048; k++) begin
      fr[k] = $urandom;
      push(2, fr[k]);
    end
    idle(3);
    check("b2b_count", 32'(q32d.size()), 32'd512);
    nf = 0;
    for (int j = 0; j < 512 && j < q32d.size(); j++) begin
      check($sformatf("b2b_out%0d", j), q32d[j], pool(32, (j / 256) * 1024, (j % 256) / 16, j % 16));
      check($sformatf("b2b_fd%0d", j), 32'(q32f[j]), 32'(j == 255 || j == 511));
      if (q32f[j]) nf++;
    end
    check("b2b_fd_total", 32'(nf), 32'd2);

    // reset mid-frame
    for (int k = 0; k < 37; k++) push(2, $urandom);
    idle(3);
    q32d.delete(); q32f.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_d", d32o, 32'h0);
    check("midrst_v", 32'(v32o), 32'h0);
    idle(2);
    rst = 1'b1;
    idle(2);
    check("midrst_quiet", 32'(q32d.size()), 32'd0);
    for (int k = 0; k < 1024; k++) begin
      fr[k] = $urandom;
      push(2, fr[k]);
    end
    idle(3);
    check("midrst_count", 32'(q32d.size()), 32'd256);
    nf = 0;
    for (int j = 0; j < 256 && j < q32d.size(); j++) begin
      check($sformatf("midrst_out%0d", j), q32d[j], pool(32, 0, j / 16, j % 16));
      if (q32f[j]) nf++;
    end
    check("midrst_fd_total", 32'(nf), 32'd1);
    if (q32f.size() == 256) check("midrst_fd_last", 32'(q32f[255]), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
